// File: rtl/priority_encoder_pkg.sv
// Shared helpers for the iterating priority encoder.
// Holds the FSM state type and width-generic bit-scan functions. The functions
// work on a MAX_WIDTH-bit zero-extended operand. Callers cast the operand in
// and the result back out to their own width.
package priority_encoder_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  // Two's-complement trick: the lowest set bit is the only bit that survives v & -v.
  function automatic logic [MAX_WIDTH-1:0] lowest_onehot(input logic [MAX_WIDTH-1:0] v);
    return v & (~v + {{(MAX_WIDTH-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic [MAX_WIDTH-1:0] highest_onehot(input logic [MAX_WIDTH-1:0] v);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // OR of indices; exact for a one-hot input, 0 for a zero input.
  function automatic logic [5:0] onehot_to_idx(input logic [MAX_WIDTH-1:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (v[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

  function automatic logic [6:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      cnt = cnt + {6'b0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational scan of one vector.
// Ports:
//   vec_i         vector to scan
//   lo_onehot_o   one-hot of the lowest set bit (0 if vec_i is zero)
//   hi_onehot_o   one-hot of the highest set bit (0 if vec_i is zero)
//   sel_onehot_o  lo or hi depending on LSB_FIRST
//   sel_idx_o     index of sel_onehot_o (0 if vec_i is zero)
//   last_o        vec_i has at most one set bit
//   cnt_o         number of set bits
module priority_encoder_core
  import priority_encoder_pkg::*;
#(
  parameter int  WIDTH     = 16,
  parameter bit  LSB_FIRST = 1'b1,
  localparam int IDX_W     = $clog2(WIDTH),
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [WIDTH-1:0] lo_onehot_o,
  output logic [WIDTH-1:0] hi_onehot_o,
  output logic [WIDTH-1:0] sel_onehot_o,
  output logic [IDX_W-1:0] sel_idx_o,
  output logic             last_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_sel;

  always_comb begin
    w_lo  = WIDTH'(lowest_onehot(MAX_WIDTH'(vec_i)));
    w_hi  = WIDTH'(highest_onehot(MAX_WIDTH'(vec_i)));
    w_sel = LSB_FIRST ? w_lo : w_hi;
  end

  assign lo_onehot_o  = w_lo;
  assign hi_onehot_o  = w_hi;
  assign sel_onehot_o = w_sel;
  assign sel_idx_o    = IDX_W'(onehot_to_idx(MAX_WIDTH'(w_sel)));
  assign cnt_o        = CNT_W'(popcount(MAX_WIDTH'(vec_i)));
  // Clearing the lowest set bit leaves zero iff there was at most one bit.
  assign last_o       = (vec_i & (vec_i - WIDTH'(1))) == '0;

endmodule

// File: rtl/priority_encoder_iter.sv
// Accepts a vector, registers lowest/highest one-hot and popcount, then emits
// one beat per set bit (a single empty beat for a zero vector).
// Ports:
//   clk_150mhz_i, rst_i (async, active-high)
//   data_i/data_val_i/data_ready_o          input vector stream
//   data_left_o/data_right_o/ones_cnt_o     summary of the last accepted vector
//   bit_onehot_o/bit_idx_o/bit_last_o/bit_empty_o/bit_val_o/bit_ready_i  beat stream
//
// state | meaning
// IDLE  | waiting for a vector; data_ready_o=1 except the first cycle out of reset
// ITER  | emitting set bits of the pending register, one per beat handshake
module priority_encoder_iter
  import priority_encoder_pkg::*;
#(
  parameter int  WIDTH     = 16,
  parameter bit  LSB_FIRST = 1'b1,
  localparam int IDX_W     = $clog2(WIDTH),
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk_150mhz_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] data_left_o,
  output logic [WIDTH-1:0] data_right_o,
  output logic [CNT_W-1:0] ones_cnt_o,
  output logic [WIDTH-1:0] bit_onehot_o,
  output logic [IDX_W-1:0] bit_idx_o,
  output logic             bit_last_o,
  output logic             bit_empty_o,
  output logic             bit_val_o,
  input  logic             bit_ready_i
);

  state_t           r_state;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_left;
  logic [WIDTH-1:0] r_right;
  logic [CNT_W-1:0] r_cnt;
  logic             r_empty;
  logic             r_data_ready;
  logic             r_bit_val;

  logic [WIDTH-1:0] w_p_sel;
  logic [IDX_W-1:0] w_p_idx;
  logic             w_p_last;
  logic [WIDTH-1:0] w_unused_p_lo;
  logic [WIDTH-1:0] w_unused_p_hi;
  logic [CNT_W-1:0] w_unused_p_cnt;

  logic [WIDTH-1:0] w_c_lo;
  logic [WIDTH-1:0] w_c_hi;
  logic [CNT_W-1:0] w_c_cnt;
  logic [WIDTH-1:0] w_unused_c_sel;
  logic [IDX_W-1:0] w_unused_c_idx;
  logic             w_unused_c_last;

  logic             w_accept;
  logic             w_beat;

  // Scan of the pending register drives the beat stream.
  priority_encoder_core #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_pending_scan (
    .vec_i        (r_pending),
    .lo_onehot_o  (w_unused_p_lo),
    .hi_onehot_o  (w_unused_p_hi),
    .sel_onehot_o (w_p_sel),
    .sel_idx_o    (w_p_idx),
    .last_o       (w_p_last),
    .cnt_o        (w_unused_p_cnt)
  );

  // Scan of the incoming vector feeds the summary registers at accept.
  priority_encoder_core #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_capture_scan (
    .vec_i        (data_i),
    .lo_onehot_o  (w_c_lo),
    .hi_onehot_o  (w_c_hi),
    .sel_onehot_o (w_unused_c_sel),
    .sel_idx_o    (w_unused_c_idx),
    .last_o       (w_unused_c_last),
    .cnt_o        (w_c_cnt)
  );

  assign w_accept = data_val_i && r_data_ready;
  assign w_beat   = r_bit_val && bit_ready_i;

  always_ff @(posedge clk_150mhz_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_pending    <= '0;
      r_left       <= '0;
      r_right      <= '0;
      r_cnt        <= '0;
      r_empty      <= 1'b0;
      r_data_ready <= 1'b0;
      r_bit_val    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Ready is held low for one cycle after reset release.
          r_data_ready <= 1'b1;
          if (w_accept) begin
            r_pending    <= data_i;
            r_left       <= w_c_lo;
            r_right      <= w_c_hi;
            r_cnt        <= w_c_cnt;
            r_empty      <= (data_i == '0);
            r_data_ready <= 1'b0;
            r_bit_val    <= 1'b1;
            r_state      <= ITER;
          end
        end
        ITER: begin
          if (w_beat) begin
            r_pending <= r_pending & ~w_p_sel;
            if (w_p_last) begin
              r_empty      <= 1'b0;
              r_bit_val    <= 1'b0;
              r_data_ready <= 1'b1;
              r_state      <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_ready_o = r_data_ready;
  assign data_left_o  = r_left;
  assign data_right_o = r_right;
  assign ones_cnt_o   = r_cnt;
  assign bit_val_o    = r_bit_val;
  // Beat fields are masked so that reset and IDLE present all-zero outputs
  // (an empty pending register would otherwise report last=1).
  assign bit_onehot_o = r_bit_val ? w_p_sel : '0;
  assign bit_idx_o    = r_bit_val ? w_p_idx : '0;
  assign bit_last_o   = r_bit_val & w_p_last;
  assign bit_empty_o  = r_bit_val & r_empty;

endmodule

// File: tb/tb_priority_encoder_iter.sv
module tb_priority_encoder_iter;

  typedef struct {
    logic [15:0] onehot;
    int          idx;
    bit          last;
    bit          empty;
  } beat_t;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    int          cnt;
  } sum_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  d4_data = '0;
  logic        d4_val = 1'b0, d4_brdy = 1'b0;
  logic        d4_ready, d4_last, d4_empty, d4_bval;
  logic [3:0]  d4_left, d4_right, d4_oh;
  logic [2:0]  d4_cnt;
  logic [1:0]  d4_idx;

  logic [15:0] d16_data = '0;
  logic        d16_val = 1'b0, d16_brdy = 1'b0;
  logic        d16_ready, d16_last, d16_empty, d16_bval;
  logic [15:0] d16_left, d16_right, d16_oh;
  logic [4:0]  d16_cnt;
  logic [3:0]  d16_idx;

  priority_encoder_iter #(.WIDTH(4), .LSB_FIRST(1'b1)) dut4 (
    .clk_150mhz_i(clk), .rst_i(rst),
    .data_i(d4_data), .data_val_i(d4_val), .data_ready_o(d4_ready),
    .data_left_o(d4_left), .data_right_o(d4_right), .ones_cnt_o(d4_cnt),
    .bit_onehot_o(d4_oh), .bit_idx_o(d4_idx), .bit_last_o(d4_last),
    .bit_empty_o(d4_empty), .bit_val_o(d4_bval), .bit_ready_i(d4_brdy)
  );

  priority_encoder_iter #(.WIDTH(16), .LSB_FIRST(1'b0)) dut16 (
    .clk_150mhz_i(clk), .rst_i(rst),
    .data_i(d16_data), .data_val_i(d16_val), .data_ready_o(d16_ready),
    .data_left_o(d16_left), .data_right_o(d16_right), .ones_cnt_o(d16_cnt),
    .bit_onehot_o(d16_oh), .bit_idx_o(d16_idx), .bit_last_o(d16_last),
    .bit_empty_o(d16_empty), .bit_val_o(d16_bval), .bit_ready_i(d16_brdy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int acc4 = 0, acc16 = 0;

  beat_t q4[$];
  beat_t q16[$];
  sum_t  s4_exp, s16_exp;
  bit    s4_pend = 0, s16_pend = 0;

  // Reference model: walk the bits in the required order.
  task automatic model(input logic [15:0] v, input int w, input bit lsb,
                       output beat_t bs[16], output int n, output sum_t s);
    int b;
    n = 0; s.lo = '0; s.hi = '0; s.cnt = 0;
    for (int i = 0; i < 16; i++) begin
      bs[i].onehot = '0; bs[i].idx = 0; bs[i].last = 0; bs[i].empty = 0;
    end
    for (int i = 0; i < w; i++) begin
      if (v[i]) begin
        s.cnt++;
        if (s.lo == '0) s.lo = 16'd1 << i;
        s.hi = 16'd1 << i;
      end
    end
    for (int k = 0; k < w; k++) begin
      b = lsb ? k : w - 1 - k;
      if (v[b]) begin
        bs[n].onehot = 16'd1 << b;
        bs[n].idx    = b;
        n++;
      end
    end
    if (n == 0) begin
      bs[0].last = 1; bs[0].empty = 1; n = 1;
    end else begin
      bs[n-1].last = 1;
    end
  endtask

  // Scoreboard for the 4-bit LSB-first instance.
  always @(negedge clk) begin
    beat_t eb;
    beat_t bs[16];
    int    n;
    sum_t  s;
    if (s4_pend) begin
      s4_pend = 0;
      n_checks++;
      if ({12'b0, d4_left} !== s4_exp.lo || {12'b0, d4_right} !== s4_exp.hi || int'(d4_cnt) !== s4_exp.cnt) begin
        n_errors++;
        $display("FAIL w4_summary: got left=%h right=%h cnt=%0d expected left=%h right=%h cnt=%0d",
                 d4_left, d4_right, d4_cnt, s4_exp.lo[3:0], s4_exp.hi[3:0], s4_exp.cnt);
      end
    end
    if (d4_bval && d4_brdy) begin
      n_checks++;
      if (q4.size() == 0) begin
        n_errors++;
        $display("FAIL w4_beat_unexpected: got idx=%0d onehot=%h, expected no beat", d4_idx, d4_oh);
      end else begin
        eb = q4.pop_front();
        if ({12'b0, d4_oh} !== eb.onehot || int'(d4_idx) !== eb.idx || d4_last !== eb.last || d4_empty !== eb.empty) begin
          n_errors++;
          $display("FAIL w4_beat: got oh=%h idx=%0d last=%b empty=%b expected oh=%h idx=%0d last=%b empty=%b",
                   d4_oh, d4_idx, d4_last, d4_empty, eb.onehot[3:0], eb.idx, eb.last, eb.empty);
        end
      end
    end
    if (d4_val && d4_ready) begin
      model({12'b0, d4_data}, 4, 1'b1, bs, n, s);
      for (int i = 0; i < n; i++) q4.push_back(bs[i]);
      s4_exp = s; s4_pend = 1; acc4++;
    end
  end

  // Scoreboard for the 16-bit MSB-first instance.
  always @(negedge clk) begin
    beat_t eb;
    beat_t bs[16];
    int    n;
    sum_t  s;
    if (s16_pend) begin
      s16_pend = 0;
      n_checks++;
      if (d16_left !== s16_exp.lo || d16_right !== s16_exp.hi || int'(d16_cnt) !== s16_exp.cnt) begin
        n_errors++;
        $display("FAIL w16_summary: got left=%h right=%h cnt=%0d expected left=%h right=%h cnt=%0d",
                 d16_left, d16_right, d16_cnt, s16_exp.lo, s16_exp.hi, s16_exp.cnt);
      end
    end
    if (d16_bval && d16_brdy) begin
      n_checks++;
      if (q16.size() == 0) begin
        n_errors++;
        $display("FAIL w16_beat_unexpected: got idx=%0d onehot=%h, expected no beat", d16_idx, d16_oh);
      end else begin
        eb = q16.pop_front();
        if (d16_oh !== eb.onehot || int'(d16_idx) !== eb.idx || d16_last !== eb.last || d16_empty !== eb.empty) begin
          n_errors++;
          $display("FAIL w16_beat: got oh=%h idx=%0d last=%b empty=%b expected oh=%h idx=%0d last=%b empty=%b",
                   d16_oh, d16_idx, d16_last, d16_empty, eb.onehot, eb.idx, eb.last, eb.empty);
        end
      end
    end
    if (d16_val && d16_ready) begin
      model(d16_data, 16, 1'b0, bs, n, s);
      for (int i = 0; i < n; i++) q16.push_back(bs[i]);
      s16_exp = s; s16_pend = 1; acc16++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({d4_ready, d4_bval, d4_last, d4_empty, d4_oh, d4_idx, d4_left, d4_right, d4_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_w4_outputs: got ready=%b val=%b last=%b left=%h cnt=%0d expected all 0",
               d4_ready, d4_bval, d4_last, d4_left, d4_cnt);
    end
    n_checks++;
    if ({d16_ready, d16_bval, d16_last, d16_empty, d16_oh, d16_idx, d16_left, d16_right, d16_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset_w16_outputs: got ready=%b val=%b last=%b left=%h cnt=%0d expected all 0",
               d16_ready, d16_bval, d16_last, d16_left, d16_cnt);
    end
    #2 rst = 1'b0;
    step();
    n_checks++;
    if (d4_ready !== 1'b1 || d16_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: got w4=%b w16=%b expected 1", d4_ready, d16_ready);
    end
  endtask

  task automatic test_w4_basic();
    d4_brdy = 1'b1; d4_data = 4'b1010; d4_val = 1'b1;
    step();
    d4_val = 1'b0;
    n_checks++;
    if (d4_left !== 4'b0010 || d4_right !== 4'b1000 || d4_cnt !== 3'd2) begin
      n_errors++;
      $display("FAIL w4_basic_summary: got left=%b right=%b cnt=%0d expected 0010 1000 2", d4_left, d4_right, d4_cnt);
    end
    n_checks++;
    if (d4_bval !== 1'b1 || d4_idx !== 2'd1 || d4_last !== 1'b0 || d4_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL w4_basic_beat0: got val=%b idx=%0d last=%b ready=%b expected 1 1 0 0", d4_bval, d4_idx, d4_last, d4_ready);
    end
    step();
    n_checks++;
    if (d4_bval !== 1'b1 || d4_idx !== 2'd3 || d4_last !== 1'b1) begin
      n_errors++;
      $display("FAIL w4_basic_beat1: got val=%b idx=%0d last=%b expected 1 3 1", d4_bval, d4_idx, d4_last);
    end
    step();
    n_checks++;
    if (d4_ready !== 1'b1 || d4_bval !== 1'b0) begin
      n_errors++;
      $display("FAIL w4_basic_ready: got ready=%b val=%b expected 1 0", d4_ready, d4_bval);
    end
  endtask

  task automatic test_w16_msb_first();
    d16_brdy = 1'b1; d16_data = 16'h8001; d16_val = 1'b1;
    step();
    d16_val = 1'b0;
    n_checks++;
    if (d16_idx !== 4'd15 || d16_last !== 1'b0 || d16_cnt !== 5'd2) begin
      n_errors++;
      $display("FAIL w16_msb_beat0: got idx=%0d last=%b cnt=%0d expected 15 0 2", d16_idx, d16_last, d16_cnt);
    end
    step();
    n_checks++;
    if (d16_idx !== 4'd0 || d16_last !== 1'b1 || d16_oh !== 16'h0001) begin
      n_errors++;
      $display("FAIL w16_msb_beat1: got idx=%0d last=%b oh=%h expected 0 1 0001", d16_idx, d16_last, d16_oh);
    end
    step();
    n_checks++;
    if (d16_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL w16_msb_ready: got %b expected 1", d16_ready);
    end
  endtask

  task automatic test_zero_vector();
    d4_brdy = 1'b1; d4_data = 4'b0000; d4_val = 1'b1;
    step();
    d4_val = 1'b0;
    n_checks++;
    if (d4_bval !== 1'b1 || d4_oh !== 4'b0 || d4_idx !== 2'd0 || d4_last !== 1'b1 || d4_empty !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_beat: got val=%b oh=%b idx=%0d last=%b empty=%b expected 1 0000 0 1 1",
               d4_bval, d4_oh, d4_idx, d4_last, d4_empty);
    end
    n_checks++;
    if (d4_left !== 4'b0 || d4_right !== 4'b0 || d4_cnt !== 3'd0) begin
      n_errors++;
      $display("FAIL zero_summary: got left=%b right=%b cnt=%0d expected 0 0 0", d4_left, d4_right, d4_cnt);
    end
    step();
    n_checks++;
    if (d4_ready !== 1'b1 || d4_bval !== 1'b0 || d4_empty !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_done: got ready=%b val=%b empty=%b expected 1 0 0", d4_ready, d4_bval, d4_empty);
    end
  endtask

  task automatic test_backpressure();
    d4_brdy = 1'b0; d4_data = 4'b0111; d4_val = 1'b1;
    step();
    d4_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (d4_bval !== 1'b1 || d4_oh !== 4'b0001 || d4_idx !== 2'd0 || d4_last !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold_%0d: got val=%b oh=%b idx=%0d last=%b expected 1 0001 0 0",
                 i, d4_bval, d4_oh, d4_idx, d4_last);
      end
      if (i < 3) begin
        d4_data = 4'b1111; d4_val = (i != 1);
        step();
      end
    end
    d4_val = 1'b0; d4_brdy = 1'b1;
    step();
    n_checks++;
    if (d4_idx !== 2'd1 || d4_last !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_beat1: got idx=%0d last=%b expected 1 0", d4_idx, d4_last);
    end
    step();
    n_checks++;
    if (d4_idx !== 2'd2 || d4_last !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_beat2: got idx=%0d last=%b expected 2 1", d4_idx, d4_last);
    end
    step();
    n_checks++;
    if (d4_ready !== 1'b1 || d4_cnt !== 3'd3) begin
      n_errors++;
      $display("FAIL bp_done: got ready=%b cnt=%0d expected 1 3", d4_ready, d4_cnt);
    end
  endtask

  task automatic test_reset_mid();
    d16_brdy = 1'b1; d16_data = 16'hFFFF; d16_val = 1'b1;
    step();
    d16_val = 1'b0;
    repeat (5) step();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({d16_ready, d16_bval, d16_last, d16_empty, d16_oh, d16_idx, d16_left, d16_right, d16_cnt} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: got ready=%b val=%b oh=%h idx=%0d cnt=%0d expected all 0",
               d16_ready, d16_bval, d16_oh, d16_idx, d16_cnt);
    end
    n_checks++;
    if (q16.size() != 11) begin
      n_errors++;
      $display("FAIL mid_reset_beats_done: got %0d outstanding expected 11", q16.size());
    end
    q16.delete(); q4.delete(); s16_pend = 0; s4_pend = 0;
    @(negedge clk);
    #1 rst = 1'b0;
    step();
    n_checks++;
    if (d16_ready !== 1'b1 || d16_bval !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_release: got ready=%b val=%b expected 1 0", d16_ready, d16_bval);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (d16_bval !== 1'b0) begin
        n_errors++;
        $display("FAIL mid_reset_residual: got val=%b expected 0 cycle %0d", d16_bval, i);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rv;
    int c;
    acc4 = 0; acc16 = 0;
    for (c = 0; c < 60000 && (acc4 < 1000 || acc16 < 1000); c++) begin
      rv = $urandom;
      d16_data = ($urandom_range(0, 7) == 0) ? 16'h0 : rv[15:0];
      d4_data  = rv[19:16];
      d16_val  = (acc16 < 1000) && ($urandom_range(0, 1) == 1);
      d4_val   = (acc4 < 1000) && ($urandom_range(0, 1) == 1);
      d16_brdy = ($urandom_range(0, 9) < 7);
      d4_brdy  = ($urandom_range(0, 9) < 6);
      step();
    end
    n_checks++;
    if (acc4 < 1000 || acc16 < 1000) begin
      n_errors++;
      $display("FAIL random_timeout: got accepts w4=%0d w16=%0d expected 1000 each", acc4, acc16);
    end
    d4_val = 1'b0; d16_val = 1'b0; d4_brdy = 1'b1; d16_brdy = 1'b1;
    for (c = 0; c < 300; c++) begin
      step();
      if (d4_ready && d16_ready && q4.size() == 0 && q16.size() == 0) break;
    end
    n_checks++;
    if (q4.size() != 0 || q16.size() != 0 || d4_ready !== 1'b1 || d16_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL random_drain: got outstanding w4=%0d w16=%0d ready=%b%b expected 0 0 11",
               q4.size(), q16.size(), d4_ready, d16_ready);
    end
  endtask

  initial begin
    test_reset();
    test_w4_basic();
    test_w16_msb_first();
    test_zero_vector();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
